count_monitor: RTL and testbench

Checker stage directly downstream of the free-running 8-bit counter. Samples the counter value and its registered "is one" flag, and locks once it sees a run of consecutive +1 increments. While locked it flags any step that is not +1 modulo 2^WIDTH and any flag misalignment, and counts wrap-arounds. Used in bring-up and labs to confirm counter/register timing without reading waveforms.

---
 rtl/count_monitor.sv | 76 +++++++
 tb/tb_count_monitor.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/count_monitor.sv
// count_monitor: locks onto a +1 counter stream, then flags step/flag errors and counts wraps.
module count_monitor #(
    parameter int WIDTH    = 8,
    parameter int LOCK_CNT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_count,
    input  logic             in_is_one,
    input  logic             clear_err,
    output logic             locked,
    output logic             err,
    output logic [7:0]       err_count,
    output logic             wrap_pulse,
    output logic [15:0]      wrap_count,
    output logic [WIDTH-1:0] expected
);
    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;
    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_prev;
    logic [3:0]       r_good, w_good_inc;
    logic             r_err, r_wrap_pulse;
    logic [7:0]       r_err_count;
    logic [15:0]      r_wrap_count;
    logic             w_match, w_flag_ok, w_ok, w_err_ev, w_wrap;
    assign expected   = r_prev + WIDTH'(1);
    assign w_match    = in_count == expected;
    assign w_flag_ok  = in_is_one == (r_prev == WIDTH'(1));
    assign w_ok       = w_match && w_flag_ok;
    assign w_err_ev   = in_valid && r_state == LOCKED && !w_ok;
    assign w_wrap     = in_valid && r_state == LOCKED && w_ok && in_count == '0;
    assign w_good_inc = r_good + 4'd1;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end
    always_comb begin
        w_next = !in_valid           ? r_state :
                 r_state == IDLE     ? ACQUIRE :
                 r_state == ACQUIRE  ? ((w_match && w_good_inc == 4'(LOCK_CNT)) ? LOCKED : ACQUIRE) :
                 w_ok                ? LOCKED : ACQUIRE;
    end
    always_comb begin
        locked     = r_state == LOCKED;
        err        = r_err;
        err_count  = r_err_count;
        wrap_pulse = r_wrap_pulse;
        wrap_count = r_wrap_count;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prev       <= '0;
            r_good       <= 4'd0;
            r_err        <= 1'b0;
            r_err_count  <= 8'd0;
            r_wrap_pulse <= 1'b0;
            r_wrap_count <= 16'd0;
        end else begin
            r_wrap_pulse <= w_wrap;
            if (w_wrap) r_wrap_count <= r_wrap_count + 16'd1;
            if (in_valid) begin
                r_prev <= in_count;
                r_good <= (r_state == ACQUIRE && w_match) ? w_good_inc : 4'd0;
            end
            // an error event on the same edge as clear_err takes precedence
            if (w_err_ev) begin
                r_err       <= 1'b1;
                r_err_count <= clear_err ? 8'd1 : (r_err_count == 8'hFF ? r_err_count : r_err_count + 8'd1);
            end else if (clear_err) begin
                r_err       <= 1'b0;
                r_err_count <= 8'd0;
            end
        end
    end
endmodule

// File: tb/tb_count_monitor.sv
// tb_count_monitor: directed plus random stimulus against a behavioural model of the monitor.
module tb_count_monitor;
    localparam int LOCK = 4;
    logic clk = 0, reset = 1, in_valid = 0, in_is_one = 0, clear_err = 0;
    logic [7:0] in_count = 0;
    logic locked, err, wrap_pulse;
    logic [7:0] err_count, expected;
    logic [15:0] wrap_count;
    int total = 0, bad = 0, lastc = 0;
    int m_prev = 0, m_good = 0, m_errc = 0, m_wc = 0;
    bit m_seen = 0, m_lock = 0, m_err = 0, m_wp = 0;

    count_monitor #(.WIDTH(8), .LOCK_CNT(LOCK)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_count(in_count),
        .in_is_one(in_is_one), .clear_err(clear_err), .locked(locked), .err(err),
        .err_count(err_count), .wrap_pulse(wrap_pulse), .wrap_count(wrap_count),
        .expected(expected)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d t=%0t", n, a, e, $time);
        end
    endtask

    // model: "seen" = past the first sample after reset, "lock" = locked
    always @(posedge clk or negedge reset) begin
        bit ev, match, fok;
        if (!reset) begin
            m_prev = 0; m_good = 0; m_errc = 0; m_wc = 0;
            m_seen = 0; m_lock = 0; m_err = 0; m_wp = 0;
        end else begin
            m_wp = 0;
            ev = 0;
            if (in_valid) begin
                match = int'(in_count) == (m_prev + 1) % 256;
                fok = in_is_one == (m_prev == 1);
                if (!m_seen) begin
                    m_seen = 1;
                    m_good = 0;
                end else if (!m_lock) begin
                    m_good = match ? m_good + 1 : 0;
                    if (m_good == LOCK) m_lock = 1;
                end else if (match && fok) begin
                    if (in_count == 0) begin
                        m_wp = 1;
                        m_wc = (m_wc + 1) % 65536;
                    end
                end else begin
                    ev = 1;
                    m_lock = 0;
                    m_good = 0;
                end
                m_prev = in_count;
            end
            if (ev) begin
                m_err = 1;
                m_errc = clear_err ? 1 : (m_errc < 255 ? m_errc + 1 : 255);
            end else if (clear_err) begin
                m_err = 0;
                m_errc = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("m_locked", locked, m_lock);
        chk("m_err", err, m_err);
        chk("m_err_count", err_count, m_errc);
        chk("m_wrap_pulse", wrap_pulse, m_wp);
        chk("m_wrap_count", wrap_count, m_wc);
        chk("m_expected", expected, (m_prev + 1) % 256);
    end

    task automatic feed(input logic v, input int c, input logic o, input logic clr);
        in_valid = v; in_count = c[7:0]; in_is_one = o; clear_err = clr;
        @(posedge clk); #1;
        in_valid = 0; clear_err = 0;
        if (v) lastc = c;
    endtask
    task automatic gf(input int c);
        feed(1, c, lastc == 1, 0);
    endtask
    task automatic gfc(input int c);
        feed(1, c, lastc == 1, 1);
    endtask

    initial begin
        #1 reset = 0;
        #1;
        chk("rst_locked", locked, 0);
        chk("rst_err", err, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_wrap_count", wrap_count, 0);
        chk("rst_expected", expected, 1);
        repeat (3) @(posedge clk);
        #2 reset = 1;
        // lock-up
        for (int k = 0; k < 5; k++) gf(k);
        chk("t1_locked", locked, 1);
        chk("t1_expected", expected, 5);
        chk("t1_err", err, 0);
        chk("t1_wrap_count", wrap_count, 0);
        // wrap
        gf(250);
        chk("t2_err", err, 1);
        chk("t2_err_count", err_count, 1);
        chk("t2_unlock", locked, 0);
        gf(251); gf(252); gf(253); gfc(254);
        chk("t2_relock", locked, 1);
        chk("t2_cleared", err_count, 0);
        gf(255); gf(0);
        chk("t2_wrap_pulse", wrap_pulse, 1);
        chk("t2_wrap_count", wrap_count, 1);
        chk("t2_err0", err, 0);
        gf(1);
        chk("t2_pulse_end", wrap_pulse, 0);
        chk("t2_wrap_hold", wrap_count, 1);
        gf(2);
        chk("t5_flag_ok", err, 0);
        chk("t5_flag_ok_lock", locked, 1);
        // skip error and relock
        gf(6); gf(7); gf(8); gf(9); gfc(10);
        chk("t3_locked10", locked, 1);
        gf(12);
        chk("t3_err", err, 1);
        chk("t3_err_count", err_count, 1);
        chk("t3_unlock", locked, 0);
        gf(13); gf(14); gf(15);
        chk("t3_not_yet", locked, 0);
        gf(16);
        chk("t3_relock", locked, 1);
        // stall
        for (int k = 17; k <= 20; k++) gf(k);
        in_count = 99;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("t4_stall_expected", expected, 21);
            chk("t4_stall_locked", locked, 1);
        end
        gf(21);
        chk("t4_locked", locked, 1);
        chk("t4_err_count", err_count, 1);
        // flag checks
        for (int k = 22; k < 256; k++) gf(k);
        gf(0); gf(1);
        chk("t5_wrap_count", wrap_count, 2);
        feed(1, 2, 0, 0);
        chk("t5_flag_err", err_count, 2);
        chk("t5_flag_unlock", locked, 0);
        for (int k = 0; k < 5; k++) gf(k);
        feed(1, 5, 1, 0);
        chk("t5_flag_err2", err_count, 3);
        chk("t5_flag_unlock2", locked, 0);
        // clear vs error, reset
        gf(6); gf(7); gf(8); gf(9);
        feed(1, 20, lastc == 1, 1);
        chk("t6_err_wins", err, 1);
        chk("t6_err_wins_count", err_count, 1);
        for (int k = 21; k <= 24; k++) gf(k);
        chk("t6_locked", locked, 1);
        #1 reset = 0;
        #1;
        chk("t6_async_locked", locked, 0);
        chk("t6_async_err", err, 0);
        chk("t6_async_wrap", wrap_count, 0);
        chk("t6_async_expected", expected, 1);
        #1 reset = 1;
        lastc = 0;
        for (int k = 0; k < 5; k++) gf(k);
        gf(9);
        chk("t6_err_pre", err_count, 1);
        feed(0, 0, 0, 1);
        chk("t6_clear_err", err, 0);
        chk("t6_clear_count", err_count, 0);
        for (int i = 0; i < 260; i++) begin
            repeat (LOCK) gf((lastc + 1) % 256);
            gf((lastc + 2) % 256);
        end
        chk("t6_saturate", err_count, 255);
        chk("t6_saturate_err", err, 1);
        repeat (LOCK) gf((lastc + 1) % 256);
        feed(1, (lastc + 2) % 256, lastc == 1, 1);
        chk("t6_sat_clear_err", err_count, 1);
        // random
        for (int i = 0; i < 3000; i++) begin
            logic v, o, clr;
            int c;
            if ($urandom_range(0, 699) == 0) begin
                #1 reset = 0;
                #2 reset = 1;
                lastc = 0;
            end
            v = $urandom_range(0, 9) != 0;
            c = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 255)) : (lastc + 1) % 256;
            o = ($urandom_range(0, 19) == 0) ? (lastc != 1) : (lastc == 1);
            clr = $urandom_range(0, 24) == 0;
            feed(v, c, o, clr);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
